tx_frame_arbiter: RTL and testbench
===================================

TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 Parameter N_CH, default 5: number of response channels sharing the UART transmitter.
REQ-002 Parameter PREFIX, default 8'hDD: frame start byte.
REQ-003 Parameter HOST_ADDR, default 8'h01: destination address written into every frame.
REQ-004 Parameter BASE_ADDR, default 8'h02: channel i source address = BASE_ADDR + i, 8-bit, wraps modulo 256.
REQ-005 Port fpga_clk_48, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port n_rst, input, 1: reset, asynchronous and active-low.
REQ-007 Port req_bus, input, N_CH: channel i requests to send one frame.
REQ-008 Port len_bus, input, N_CH*8: channel i payload length, bits [8i+7:8i]; valid while req_bus[i] is high.
REQ-009 Port data_bus, input, N_CH*8: channel i payload byte, bits [8i+7:8i].
REQ-010 Port valid_bus, input, N_CH: channel i payload byte valid.
REQ-011 Port ready_bus, output, N_CH: channel i payload byte accepted this cycle when ready and valid are both high.
REQ-012 Port tx_data, output, 8: byte to the UART transmitter.
REQ-013 Port tx_valid, output, 1: tx_data valid.
REQ-014 Port tx_ready, input, 1: UART transmitter accepts tx_data this cycle.
REQ-015 Port grant, output, N_CH: one-hot owner of the current frame; all zeros when idle.
REQ-016 Port busy, output, 1: high in any state other than IDLE.
REQ-017 Port my_state, output, 3: debug copy of the state register.

Function
REQ-018 States SHALL be IDLE=0, PREFIX=1, SRC=2, DEST=3, LEN=4, PAYLOAD=5; codes 6-7 SHALL return to IDLE on the next clock edge.
REQ-019 In IDLE, when any req_bus bit is high, the block SHALL select a winner round-robin, starting at (last_grant+1) mod N_CH and searching upward with wrap-around.
REQ-020 On selection the block SHALL register grant (one-hot), latch len_bus[winner] into len_r, clear cnt, and enter PREFIX on the same edge; latency from req to first tx_valid is 1 cycle.
REQ-021 Header bytes SHALL be driven with tx_valid=1, in this order: PREFIX, then BASE_ADDR+winner in SRC, then HOST_ADDR in DEST, then len_r in LEN.
REQ-022 Each header state SHALL advance only on tx_valid&&tx_ready; it holds tx_data stable while stalled.
REQ-023 LEN SHALL advance to PAYLOAD if len_r!=0, else to IDLE.
REQ-024 In PAYLOAD the block SHALL pass through combinationally: tx_data=data_bus[winner], tx_valid=valid_bus[winner], ready_bus[winner]=tx_ready; all other ready_bus bits are 0.
REQ-025 Each payload transfer SHALL increment 8-bit cnt; on the transfer where cnt==len_r-1 the block SHALL return to IDLE, clear grant, and store the winner as last_grant.
REQ-026 Outside PAYLOAD, ready_bus SHALL be all zeros.
REQ-027 Outside the header and PAYLOAD states, tx_valid SHALL be 0 and tx_data SHALL be 8'h00.
REQ-028 Once a channel is granted, deassertion of its req_bus bit or a change in len_bus SHALL NOT affect the frame in progress.
REQ-029 A request from another channel during a frame SHALL be held pending and considered at the next IDLE cycle.
REQ-030 The block SHALL spend at least one cycle in IDLE between frames.

Reset
REQ-031 While n_rst=0: state=IDLE, grant=0, busy=0, len_r=0, cnt=0, last_grant=N_CH-1 (so channel 0 wins first), ready_bus=0, tx_valid=0, tx_data=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately with no further bytes emitted; the first frame after release starts with PREFIX.

Verification
REQ-033 After reset, req_bus=5'b00100, len=3, payload 0xA1 0xA2 0xA3, tx_ready=1 -> tx emits DD, 04, 01, 03, A1, A2, A3; grant=5'b00100 throughout; busy falls after A3.
REQ-034 req_bus=5'b10001 held continuously, len=1 each -> frames alternate: channel 0 (src 02), then channel 4 (src 06), then channel 0; no channel is granted twice in a row.
REQ-035 len=0 on channel 1 -> tx emits DD, 03, 01, 00; ready_bus stays 0; state returns to IDLE after LEN.
REQ-036 tx_ready toggled 0/1 randomly and valid_bus gapped during the payload -> byte order and count are unchanged; tx_data is stable whenever tx_valid=1 and tx_ready=0.
REQ-037 n_rst pulsed low during PAYLOAD of a 6-byte frame after 2 bytes -> outputs reach reset values asynchronously; the next frame restarts from PREFIX with the full length.
REQ-038 Channel 3 req dropped after grant, with len_bus changed to 9 -> the frame still completes with the originally latched length.

Source files
------------

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that wraps one channel's payload in a
// PREFIX/SRC/DEST/LEN header and streams it to a shared UART transmitter.
module tx_frame_arbiter #(
    parameter int unsigned N_CH      = 5,
    parameter logic [7:0]  PREFIX    = 8'hDD,
    parameter logic [7:0]  HOST_ADDR = 8'h01,
    parameter logic [7:0]  BASE_ADDR = 8'h02
) (
    input  logic              fpga_clk_48,
    input  logic              n_rst,
    input  logic [N_CH-1:0]   req_bus,
    input  logic [N_CH*8-1:0] len_bus,
    input  logic [N_CH*8-1:0] data_bus,
    input  logic [N_CH-1:0]   valid_bus,
    output logic [N_CH-1:0]   ready_bus,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [N_CH-1:0]   grant,
    output logic              busy,
    output logic [2:0]        my_state
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPrefix  = 3'd1,
        StSrc     = 3'd2,
        StDest    = 3'd3,
        StLen     = 3'd4,
        StPayload = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [N_CH-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [IDX_W-1:0]   pick;
    logic               found;

    // Search upward from the channel after the last completed owner, wrapping.
    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] cand;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx  = (32'(last_q) + i) % N_CH;
            cand = IDX_W'(idx);
            if (!found && req_bus[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        win_d     = win_q;
        last_d    = last_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        ready_bus = '0;

        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d       = StPrefix;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    win_d         = pick;
                    len_d         = len_bus[8*pick +: 8];
                    cnt_d         = 8'h00;
                end
            end
            StPrefix: begin
                tx_valid = 1'b1;
                tx_data  = PREFIX;
                if (tx_ready) state_d = StSrc;
            end
            StSrc: begin
                tx_valid = 1'b1;
                tx_data  = BASE_ADDR + 8'(win_q);
                if (tx_ready) state_d = StDest;
            end
            StDest: begin
                tx_valid = 1'b1;
                tx_data  = HOST_ADDR;
                if (tx_ready) state_d = StLen;
            end
            StLen: begin
                tx_valid = 1'b1;
                tx_data  = len_q;
                if (tx_ready) begin
                    if (len_q != 8'h00) begin
                        state_d = StPayload;
                    end else begin
                        // Empty frame still counts as a turn for fairness.
                        state_d = StIdle;
                        grant_d = '0;
                        last_d  = win_q;
                    end
                end
            end
            StPayload: begin
                tx_valid         = valid_bus[win_q];
                tx_data          = data_bus[8*win_q +: 8];
                ready_bus[win_q] = tx_ready;
                if (valid_bus[win_q] && tx_ready) begin
                    cnt_d = cnt_q + 8'h01;
                    if (cnt_q == len_q - 8'h01) begin
                        state_d = StIdle;
                        grant_d = '0;
                        last_d  = win_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge fpga_clk_48 or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            win_q   <= '0;
            last_q  <= IDX_W'(N_CH - 1);
            len_q   <= 8'h00;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            win_q   <= win_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q != StIdle);
    assign my_state = state_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: directed scenarios plus randomized request
// traffic checked against a frame-level reference model.
module tb_tx_frame_arbiter;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [N-1:0]   req_bus, valid_bus, ready_bus, grant;
    logic [N*8-1:0] len_bus, data_bus;
    logic [7:0]     tx_data;
    logic           tx_valid, tx_ready, busy;
    logic [2:0]     my_state;

    always #5 clk = ~clk;

    tx_frame_arbiter dut (
        .fpga_clk_48 (clk),
        .n_rst       (n_rst),
        .req_bus     (req_bus),
        .len_bus     (len_bus),
        .data_bus    (data_bus),
        .valid_bus   (valid_bus),
        .ready_bus   (ready_bus),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .my_state    (my_state)
    );

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] pay [N][16];
    int         ptr [N];
    logic [7:0] lens [N];
    logic [7:0] cap [$];
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         ready_seen, bad_ready;
    int         model_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requester after the last owner, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++)
            if (r[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic drive_bus();
        for (int c = 0; c < N; c++) begin
            len_bus[c*8 +: 8]  = lens[c];
            data_bus[c*8 +: 8] = pay[c][ptr[c] % 16];
        end
    endtask

    // Sample at the falling edge, then return just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (prev_stall && tx_valid) chk("stall_hold", tx_data, prev_data);
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (tx_valid && tx_ready) cap.push_back(tx_data);
        if (ready_bus != '0) ready_seen = 1'b1;
        if ((ready_bus & ~grant) != '0) bad_ready = 1'b1;
        for (int c = 0; c < N; c++)
            if (ready_bus[c] && valid_bus[c]) ptr[c]++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, my_state, 3'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_grant"}, grant, '0);
        chk({tag, "_txv"}, tx_valid, 1'b0);
        chk({tag, "_txd"}, tx_data, 8'h00);
        chk({tag, "_rdy"}, ready_bus, '0);
    endtask

    task automatic do_reset();
        n_rst      = 1'b0;
        req_bus    = '0;
        valid_bus  = '0;
        tx_ready   = 1'b0;
        prev_stall = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        n_rst      = 1'b1;
        model_last = N - 1;
    endtask

    task automatic run_frame(input int ch, input int len, input bit rnd, input bit gaps,
                             input bit keep, input bit mutate);
        logic [7:0]   exp [$];
        logic [N-1:0] onehot;
        bit started, done, bad_grant;
        started   = 0;
        done      = 0;
        bad_grant = 0;
        onehot    = '0;
        onehot[ch] = 1'b1;
        exp = {8'hDD, 8'(8'h02 + ch), 8'h01, 8'(len)};
        for (int k = 0; k < len; k++) exp.push_back(pay[ch][k]);
        cap.delete();
        ptr[ch]    = 0;
        ready_seen = 0;
        bad_ready  = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int c = 0; c < N; c++)
                valid_bus[c] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            drive_bus();
            step();
            if (busy) begin
                if (!started && mutate) begin
                    req_bus[ch] = 1'b0;
                    lens[ch]    = 8'd9;
                end
                started = 1;
                if (grant !== onehot) bad_grant = 1;
            end else if (started) begin
                done = 1;
            end
        end
        chk($sformatf("ch%0d_done", ch), done, 1'b1);
        chk($sformatf("ch%0d_grant_held", ch), bad_grant, 1'b0);
        chk($sformatf("ch%0d_ready_owner", ch), bad_ready, 1'b0);
        chk($sformatf("ch%0d_nbytes", ch), cap.size(), exp.size());
        for (int k = 0; k < exp.size() && k < cap.size(); k++)
            chk($sformatf("ch%0d_byte%0d", ch, k), cap[k], exp[k]);
        if (len == 0) chk($sformatf("ch%0d_no_ready", ch), ready_seen, 1'b0);
        chk($sformatf("ch%0d_idle_grant", ch), grant, '0);
        if (!keep) req_bus[ch] = 1'b0;
        model_last = ch;
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            ptr[c]  = 0;
            lens[c] = 8'd0;
            for (int k = 0; k < 16; k++) pay[c][k] = 8'($urandom);
        end
        len_bus  = '0;
        data_bus = '0;
        do_reset();

        // Single 3-byte frame on channel 2.
        lens[2] = 8'd3;
        pay[2][0] = 8'hA1; pay[2][1] = 8'hA2; pay[2][2] = 8'hA3;
        req_bus = 5'b00100;
        run_frame(pick(req_bus, model_last), 3, 0, 0, 0, 0);

        // Two channels held continuously must alternate.
        do_reset();
        lens[0] = 8'd1; lens[4] = 8'd1;
        req_bus = 5'b10001;
        for (int f = 0; f < 3; f++) run_frame(pick(req_bus, model_last), 1, 0, 0, 1, 0);
        req_bus = '0;

        // Zero-length frame.
        lens[1] = 8'd0;
        req_bus = 5'b00010;
        run_frame(pick(req_bus, model_last), 0, 0, 0, 0, 0);

        // Backpressure and gapped payload.
        lens[3] = 8'd8;
        req_bus = 5'b01000;
        run_frame(pick(req_bus, model_last), 8, 1, 1, 0, 0);

        // Request dropped and length changed after grant.
        lens[3] = 8'd4;
        req_bus = 5'b01000;
        run_frame(pick(req_bus, model_last), 4, 0, 0, 0, 1);

        // Reset in the middle of a 6-byte payload.
        lens[2] = 8'd6;
        req_bus = 5'b00100;
        cap.delete();
        ptr[2] = 0;
        for (int cyc = 0; cyc < 100 && cap.size() < 6; cyc++) begin
            tx_ready  = 1'b1;
            valid_bus = '1;
            drive_bus();
            step();
        end
        chk("abort_pre_bytes", cap.size(), 6);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        chk("abort_hold_txv", tx_valid, 1'b0);
        n_rst      = 1'b1;
        prev_stall = 1'b0;
        model_last = N - 1;
        run_frame(pick(req_bus, model_last), 6, 0, 0, 0, 0);

        // Random traffic with pending requests.
        for (int it = 0; it < 14; it++) begin
            int ch;
            for (int c = 0; c < N; c++) begin
                if (!req_bus[c] && $urandom_range(0, 1) == 1) begin
                    req_bus[c] = 1'b1;
                    lens[c]    = 8'($urandom_range(0, 6));
                    for (int k = 0; k < 16; k++) pay[c][k] = 8'($urandom);
                end
            end
            if (req_bus == '0) begin
                req_bus[0] = 1'b1;
                lens[0]    = 8'd2;
            end
            ch = pick(req_bus, model_last);
            run_frame(ch, int'(lens[ch]), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
